// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding and common keyboard command/response bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INHIBIT  = 3'd1,
        BITS     = 3'd2,
        ACK      = 3'd3,
        WAITIDLE = 3'd4
    } ps2_state_e;

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_LEDS   = 8'hED;
    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_RESEND = 8'hFE;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a stability filter for one raw PS/2 pin.
// The filtered level only changes after the synchronised input has held a new value for FILTER clocks.
module ps2_line_filter #(
    parameter int FILTER = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic level
);

    localparam int CW = (FILTER < 2) ? 1 : $clog2(FILTER + 1);

    logic [1:0]    sync_q, sync_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync_d  = {sync_q[0], din};
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(FILTER - 1)) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Idle PS/2 lines are pulled high, so the filter wakes up at 1.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the clock, issues a start bit, shifts out one byte on device clocks.
// Define PS2_TX_RETRY_EN to make one automatic retry of the same byte before reporting an error.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 56000000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_MS = 15,
    parameter int FILTER     = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2kCk,
    input  logic       ps2kD,
    output logic       ckLow,
    output logic       dLow,
    input  logic       strb,
    input  logic [7:0] code,
    output logic       busy,
    output logic       done,
    output logic       error,
    output ps2_state_e dbg_state
);

    localparam int INH_CNT = CLK_HZ / 1000000 * INHIBIT_US;
    localparam int TO_CNT  = CLK_HZ / 1000 * TIMEOUT_MS;
    localparam int INH_W   = $clog2(INH_CNT);
    localparam int TO_W    = $clog2(TO_CNT);

    logic ck_level, d_level, ck_fall;

    ps2_line_filter #(.FILTER(FILTER)) u_ck_filter (
        .clock (clock),
        .reset (reset),
        .din   (ps2kCk),
        .level (ck_level)
    );

    ps2_line_filter #(.FILTER(FILTER)) u_d_filter (
        .clock (clock),
        .reset (reset),
        .din   (ps2kD),
        .level (d_level)
    );

    ps2_state_e       state_q, state_d;
    logic [7:0]       code_q, code_d;
    logic             par_q, par_d;
    logic [3:0]       idx_q, idx_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             ck_low_q, ck_low_d, d_low_q, d_low_d;
    logic             busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic             ck_prev_q;
    logic             fail, in_frame;
`ifdef PS2_TX_RETRY_EN
    logic             retry_q, retry_d;
`endif

    assign ck_fall  = ck_prev_q & ~ck_level;
    assign in_frame = (state_q == BITS) || (state_q == ACK) || (state_q == WAITIDLE);

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        par_d     = par_q;
        idx_d     = idx_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = in_frame ? to_cnt_q + 1'b1 : to_cnt_q;
        ck_low_d  = ck_low_q;
        d_low_d   = d_low_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        fail      = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_d   = retry_q;
`endif
        case (state_q)
            IDLE: begin
                // A request landing on the done/error clock is still treated as busy.
                if (strb && !done_q && !error_q) begin
                    code_d    = code;
                    par_d     = odd_parity(code);
                    busy_d    = 1'b1;
                    ck_low_d  = 1'b1;
                    d_low_d   = 1'b0;
                    inh_cnt_d = '0;
                    state_d   = INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_d   = 1'b0;
`endif
                end
            end
            INHIBIT: begin
                inh_cnt_d = inh_cnt_q + 1'b1;
                if (inh_cnt_q == INH_W'(INH_CNT - 2)) begin
                    d_low_d = 1'b1;
                end
                if (inh_cnt_q == INH_W'(INH_CNT - 1)) begin
                    ck_low_d = 1'b0;
                    idx_d    = '0;
                    to_cnt_d = '0;
                    state_d  = BITS;
                end
            end
            BITS: begin
                if (ck_fall) begin
                    if (idx_q < 4'd8) begin
                        d_low_d = ~code_q[idx_q[2:0]];
                    end else if (idx_q == 4'd8) begin
                        d_low_d = ~par_q;
                    end else begin
                        d_low_d = 1'b0;
                        state_d = ACK;
                    end
                    idx_d = idx_q + 1'b1;
                end
            end
            ACK: begin
                if (ck_fall) begin
                    if (!d_level) state_d = WAITIDLE;
                    else          fail    = 1'b1;
                end
            end
            WAITIDLE: begin
                if (ck_level && d_level) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Timeout is evaluated last so it overrides an ack or done on the same clock.
        if (in_frame && to_cnt_q == TO_W'(TO_CNT - 1)) begin
            fail = 1'b1;
        end

        if (fail) begin
            ck_low_d = 1'b0;
            d_low_d  = 1'b0;
            done_d   = 1'b0;
`ifdef PS2_TX_RETRY_EN
            if (!retry_q) begin
                retry_d   = 1'b1;
                ck_low_d  = 1'b1;
                inh_cnt_d = '0;
                busy_d    = 1'b1;
                state_d   = INHIBIT;
            end else begin
                error_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
`else
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            code_q    <= '0;
            par_q     <= 1'b0;
            idx_q     <= '0;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            ck_low_q  <= 1'b0;
            d_low_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            ck_prev_q <= 1'b1;
`ifdef PS2_TX_RETRY_EN
            retry_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            par_q     <= par_d;
            idx_q     <= idx_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            ck_low_q  <= ck_low_d;
            d_low_q   <= d_low_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            ck_prev_q <= ck_level;
`ifdef PS2_TX_RETRY_EN
            retry_q   <= retry_d;
`endif
        end
    end

    assign ckLow     = ck_low_q;
    assign dLow      = d_low_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a 10 kHz PS/2 device model on open-drain lines, with frame and response scoreboards.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       strb  = 1'b0;
    logic [7:0] code  = 8'h00;
    logic       dev_ck = 1'b1;
    logic       dev_d  = 1'b1;
    logic       ckLow, dLow, busy, done, error;
    logic       ps2kCk, ps2kD;
    ps2_state_e dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // Expected frame: [0] start, [8:1] data LSB first, [9] parity, [10] stop.
    logic [10:0] exp_frame_q[$];
    // Expected response: {error, done}.
    logic [1:0]  exp_resp_q[$];

    assign ps2kCk = ~ckLow & dev_ck;
    assign ps2kD  = ~dLow & dev_d;

    ps2_host_tx #(
        .CLK_HZ     (1000000),
        .INHIBIT_US (100),
        .TIMEOUT_MS (2),
        .FILTER     (2)
    ) dut (
        .clock     (clock),
        .reset     (rst_n),
        .ps2kCk    (ps2kCk),
        .ps2kD     (ps2kD),
        .ckLow     (ckLow),
        .dLow      (dLow),
        .strb      (strb),
        .code      (code),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired, expected event not seen", name);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Driver tasks
    task automatic send(input logic [7:0] c, input logic push, input logic [10:0] frame, input logic [1:0] resp);
        if (push) begin
            exp_frame_q.push_back(frame);
            exp_resp_q.push_back(resp);
        end
        @(posedge clock);
        #1;
        strb = 1'b1;
        code = c;
        @(posedge clock);
        #1;
        strb = 1'b0;
    endtask

    task automatic measure_inhibit();
        int n;
        n = 0;
        @(negedge clock);
        while (ckLow === 1'b1 && n < 1000) begin
            n++;
            @(negedge clock);
        end
        check("inhibit_len", n, 100);
        check("start_bit_dlow", {31'd0, dLow}, 1);
    endtask

    task automatic device_frame(input int nclk, input logic ack);
        logic [10:0] bits;
        int n;
        bits = '0;
        n = 0;
        while (ckLow !== 1'b0 && n < 3000) begin
            tick(1);
            n++;
        end
        if (n >= 3000) begin
            bound_fail("dev_wait_release");
            return;
        end
        bits[0] = ps2kD;
        tick(20);
        for (int i = 1; i <= nclk; i++) begin
            dev_ck = 1'b0;
            tick(50);
            if (i <= 10) bits[i] = ps2kD;
            dev_ck = 1'b1;
            if (i == 10 && ack) begin
                tick(25);
                dev_d = 1'b0;
                tick(25);
            end else if (i == 11) begin
                tick(10);
                dev_d = 1'b1;
            end else begin
                tick(50);
            end
        end
        if (nclk == 11) begin
            if (exp_frame_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL frame_unexpected: got 0x%0h, expected no frame", bits);
            end else begin
                check("frame", {21'd0, bits}, {21'd0, exp_frame_q.pop_front()});
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            tick(1);
            n++;
        end
        if (n >= 5000) bound_fail(name);
        tick(30);
    endtask

    // Response monitor / scoreboard
    always @(negedge clock) begin
        if (rst_n && (done === 1'b1 || error === 1'b1)) begin
            if (exp_resp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL resp_unexpected: done=%b error=%b, expected no response", done, error);
            end else begin
                check("resp", {30'd0, error, done}, {30'd0, exp_resp_q.pop_front()});
                check("busy_at_resp", {31'd0, busy}, 0);
            end
        end
    end

    // Directed vectors: code and hand-computed frame {stop, parity, data, start}
    logic [7:0]  vec_code  [4] = '{8'hED, 8'h00, 8'h01, 8'hFF};
    logic [10:0] vec_frame [4] = '{11'h7DA, 11'h600, 11'h402, 11'h7FE};

    initial begin
        int n;
        int seen;

        // Reset state
        rst_n = 1'b0;
        tick(5);
        check("rst_ckLow", {31'd0, ckLow}, 0);
        check("rst_dLow",  {31'd0, dLow}, 0);
        check("rst_busy",  {31'd0, busy}, 0);
        check("rst_done",  {31'd0, done}, 0);
        check("rst_error", {31'd0, error}, 0);
        check("rst_state", {29'd0, dbg_state}, {29'd0, IDLE});
        rst_n = 1'b1;
        tick(20);

        // Normal frames, device acks
        for (int v = 0; v < 4; v++) begin
            send(vec_code[v], 1'b1, vec_frame[v], 2'b01);
            check("busy_after_strb", {31'd0, busy}, 1);
            measure_inhibit();
            device_frame(11, 1'b1);
            wait_idle("idle_after_ack");
        end

        // Device never clocks: timeout
        send(8'hED, 1'b0, 11'h0, 2'b10);
        exp_resp_q.push_back(2'b10);
        measure_inhibit();
        n = 0;
        while (error !== 1'b1 && n < 10000) begin
            @(negedge clock);
            n++;
        end
`ifdef PS2_TX_RETRY_EN
        check("timeout_len", n, 4100);
`else
        check("timeout_len", n, 2000);
`endif
        check("timeout_ckLow", {31'd0, ckLow}, 0);
        check("timeout_dLow",  {31'd0, dLow}, 0);
        wait_idle("idle_after_timeout");

        // Nack at the 11th clock
        exp_frame_q.push_back(11'h7FE);
`ifdef PS2_TX_RETRY_EN
        exp_frame_q.push_back(11'h7FE);
`endif
        send(8'hFF, 1'b0, 11'h0, 2'b10);
        exp_resp_q.push_back(2'b10);
        measure_inhibit();
        device_frame(11, 1'b0);
`ifdef PS2_TX_RETRY_EN
        device_frame(11, 1'b0);
`endif
        wait_idle("idle_after_nack");

        // Reset during bit 4, then a clean frame
        send(8'hED, 1'b0, 11'h0, 2'b00);
        measure_inhibit();
        device_frame(5, 1'b1);
        @(posedge clock);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ckLow", {31'd0, ckLow}, 0);
        check("midrst_dLow",  {31'd0, dLow}, 0);
        check("midrst_busy",  {31'd0, busy}, 0);
        dev_ck = 1'b1;
        dev_d  = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(20);
        send(8'h3C, 1'b1, 11'h678, 2'b01);
        measure_inhibit();
        device_frame(11, 1'b1);
        wait_idle("idle_after_rst_frame");

        // strb while busy and on the done clock
        send(8'h80, 1'b1, 11'h500, 2'b01);
        tick(10);
        strb = 1'b1;
        code = 8'h00;
        tick(1);
        strb = 1'b0;
        device_frame(11, 1'b1);
        n = 0;
        while (done !== 1'b1 && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (n >= 500) bound_fail("done_wait");
        strb = 1'b1;
        code = 8'h01;
        @(posedge clock);
        #1;
        strb = 1'b0;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (ckLow === 1'b1 || busy === 1'b1) seen++;
        end
        check("no_second_frame", seen, 0);

        // Scoreboards drained
        check("frames_left", exp_frame_q.size(), 0);
        check("resps_left",  exp_resp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
